ram_8k_fifo: RTL and testbench
==============================

RAM_8K_FIFO -- requirements
Module: ram_8k_fifo

Interface
REQ-001 SHALL have parameter data_width, default 18, stored word width, legal 1..18.
REQ-002 SHALL have parameter addr_width, default 9, depth = 2**addr_width, legal 9..11.
REQ-003 SHALL have parameter reg_rd, default 0: 0 = one-cycle read, 1 = extra output pipeline register.
REQ-004 SHALL have parameter af_thresh, default 2**addr_width-4: Almost_Full asserts when Count >= af_thresh.
REQ-005 SHALL have parameter ae_thresh, default 4: Almost_Empty asserts when Count <= ae_thresh.
REQ-006 SHALL have port Clk, in, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port Rst, in, 1, reset, synchronous, active-high.
REQ-008 SHALL have port Flush, in, 1, synchronous clear of contents and flags.
REQ-009 SHALL have port Push, in, 1, write request.
REQ-010 SHALL have port WD, in, data_width, write data.
REQ-011 SHALL have port Pop, in, 1, read request.
REQ-012 SHALL have port RD, out, data_width, read data.
REQ-013 SHALL have port RD_Valid, out, 1, RD holds a popped word this cycle.
REQ-014 SHALL have ports Full, Empty, Almost_Full and Almost_Empty, out, 1 each, status flags.
REQ-015 SHALL have port Count, out, addr_width+1, current occupancy.
REQ-016 SHALL have ports Overflow and Underflow, out, 1 each, sticky error flags.

Function
REQ-017 SHALL accept a push when Push=1 and (Full=0 or Pop is accepted the same cycle); the accepted push writes WD at wptr and increments wptr modulo depth.
REQ-018 SHALL accept a pop when Pop=1 and Empty=0; the accepted pop reads at rptr and increments rptr modulo depth.
REQ-019 SHALL, on full with simultaneous Push and Pop, accept both, leave Count unchanged and keep Full=1.
REQ-020 SHALL, on empty with simultaneous Push and Pop, accept only the push, set Underflow and make Count=1.
REQ-021 SHALL ignore a push when Full=1 without a pop and set Overflow; memory and pointers stay unchanged.
REQ-022 SHALL ignore a pop when Empty=1 and set Underflow.
REQ-023 SHALL present popped data on RD with RD_Valid=1 exactly 1 cycle (reg_rd=0) or 2 cycles (reg_rd=1) after the accepting edge; RD SHALL hold its last value while RD_Valid=0.
REQ-024 SHALL update Count, Full (Count==depth), Empty (Count==0) and the almost flags registered, in the same cycle as the accepting edge; a word pushed at edge N is poppable at edge N+1.
REQ-025 SHALL keep wrap-around transparent: pointers roll from depth-1 to 0 with no effect on Count or flags.
REQ-026 SHALL, on Flush=1, zero pointers and Count, set Empty=1 and Almost_Empty=1, clear Full, Almost_Full, Overflow, Underflow and RD_Valid, including any in-flight pipelined read; RD and memory contents are unchanged; Push and Pop in that cycle are ignored.
REQ-027 SHALL clear Overflow and Underflow only on Rst or Flush.
REQ-028 SHALL have a read path with no bypass: memory is read-before-write with respect to the same address.

Reset
REQ-029 SHALL, on Rst=1 at a rising Clk edge, set RD=0, RD_Valid=0, Count=0, Empty=1, Almost_Empty=1, Full=0, Almost_Full=0, Overflow=0, Underflow=0, and clear both pointers and the pipeline stage.
REQ-030 SHALL give Rst priority over Flush, Push and Pop; memory contents are undefined after reset.
REQ-031 SHALL allow Rst mid-operation and discard any pending read.

Structure
REQ-032 SHALL place the legal-range constants, default threshold expressions and the pointer/count width function in a shared package ram_8k_pkg.
REQ-033 SHALL instantiate exactly one sub-module, ram_8k_sdp: a simple dual-port synchronous RAM, depth x data_width, one write port and one registered read port on Clk.
REQ-034 SHALL keep pointer, count and flag logic and the optional output register in ram_8k_fifo.

Verification
REQ-035 SHALL cover fill: with defaults, push 512 words 0..511 -> Full=1 at Count=512; Almost_Full first seen at Count=508; 513th push sets Overflow.
REQ-036 SHALL cover drain: pop 512 words -> RD=0..511 in order, 1 cycle after each pop; Empty=1 after the last; an extra pop sets Underflow and RD_Valid stays 0.
REQ-037 SHALL cover full with simultaneous push/pop: at Count=512, Push=1 with WD=0x2AAAA and Pop=1 -> Count stays 512, RD=oldest word, 0x2AAAA read last.
REQ-038 SHALL cover wrap-around: 10 cycles of 300 pushes and 300 pops -> data integrity, Count never exceeds 300.
REQ-039 SHALL cover read pipeline: reg_rd=1, data_width=9, addr_width=11, push 0x1FF then pop -> RD=0x1FF with RD_Valid=1 exactly 2 cycles later.
REQ-040 SHALL cover clear: Flush or Rst asserted with a pop in flight and Count=5 -> RD_Valid stays 0 next cycle, Count=0, Empty=1, sticky flags cleared.

Source files
------------

// File: rtl/ram_8k_pkg.sv
// Shared constants and helpers for the 8K-class FIFO: legal parameter ranges,
// default flag thresholds and the occupancy counter width.
package ram_8k_pkg;

    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 18;
    localparam int ADDR_WIDTH_MIN = 9;
    localparam int ADDR_WIDTH_MAX = 11;
    localparam int AE_THRESH_DEF  = 4;
    localparam int AF_MARGIN      = 4;

    function automatic int af_thresh_def(input int aw);
        return (1 << aw) - AF_MARGIN;
    endfunction

    // Count must represent 0..depth inclusive, hence one bit wider than a pointer.
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/ram_8k_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module ram_8k_sdp
    import ram_8k_pkg::*;
#(
    parameter int data_width = 18,
    parameter int addr_width = 9
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    localparam int DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem [DEPTH];
    logic [data_width-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register holds its value between reads so RD is stable when idle.
    always_ff @(posedge Clk) begin
        if (Rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_8k_fifo.sv
// Synchronous FIFO on a single SDP RAM with registered status flags, sticky
// error flags and an optional extra read pipeline register.
module ram_8k_fifo
    import ram_8k_pkg::*;
#(
    parameter int data_width = 18,
    parameter int addr_width = 9,
    parameter int reg_rd     = 0,
    parameter int af_thresh  = af_thresh_def(addr_width),
    parameter int ae_thresh  = AE_THRESH_DEF
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               Flush,
    input  logic                               Push,
    input  logic [data_width-1:0]              WD,
    input  logic                               Pop,
    output logic [data_width-1:0]              RD,
    output logic                               RD_Valid,
    output logic                               Full,
    output logic                               Empty,
    output logic                               Almost_Full,
    output logic                               Almost_Empty,
    output logic [cnt_width(addr_width)-1:0]   Count,
    output logic                               Overflow,
    output logic                               Underflow
);

    localparam int CW = cnt_width(addr_width);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << addr_width);
    localparam logic [CW-1:0] AF_C    = CW'(af_thresh);
    localparam logic [CW-1:0] AE_C    = CW'(ae_thresh);

    if (data_width < DATA_WIDTH_MIN || data_width > DATA_WIDTH_MAX ||
        addr_width < ADDR_WIDTH_MIN || addr_width > ADDR_WIDTH_MAX) begin : g_bad_param
        $error("ram_8k_fifo: data_width/addr_width out of legal range");
    end

    logic [addr_width-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [1:0]            vld_pipe_q, vld_pipe_d;
    logic [data_width-1:0] rd_q, rd_d;
    logic [data_width-1:0] ram_rdata;
    logic                  do_push, do_pop;

    // A push into a full FIFO is legal only when a pop frees the slot this cycle.
    always_comb begin
        do_pop  = Pop && !empty_q && !Flush;
        do_push = Push && (!full_q || do_pop) && !Flush;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q | (Push && !do_push);
        unf_d      = unf_q | (Pop && empty_q);
        vld_pipe_d = {vld_pipe_q[0], do_pop};
        rd_d       = vld_pipe_q[0] ? ram_rdata : rd_q;

        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // Flush drops contents and any in-flight read but leaves RD untouched.
        if (Flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            full_d     = 1'b0;
            empty_d    = 1'b1;
            af_d       = 1'b0;
            ae_d       = 1'b1;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            vld_pipe_d = '0;
            rd_d       = rd_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            vld_pipe_q <= '0;
            rd_q       <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            vld_pipe_q <= vld_pipe_d;
            rd_q       <= rd_d;
        end
    end

    ram_8k_sdp #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .Clk   (Clk),
        .Rst   (Rst),
        .we    (do_push),
        .waddr (wptr_q),
        .wdata (WD),
        .re    (do_pop),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign RD           = (reg_rd != 0) ? rd_q : ram_rdata;
    assign RD_Valid     = (reg_rd != 0) ? vld_pipe_q[1] : vld_pipe_q[0];
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule

// File: tb/tb_ram_8k_fifo.sv
// Randomized bench for ram_8k_fifo: a default instance and a 9x2048 reg_rd=1
// instance share one stimulus stream and are each checked against a queue model.
module tb_ram_8k_fifo;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst, flush, push, pop;
    logic [17:0] wd;

    logic [17:0] rd0;
    logic        rdv0, full0, empty0, af0, ae0, ov0, un0;
    logic [9:0]  cnt0;
    logic [8:0]  rd1;
    logic        rdv1, full1, empty1, af1, ae1, ov1, un1;
    logic [11:0] cnt1;

    ram_8k_fifo dut0 (
        .Clk(Clk), .Rst(rst), .Flush(flush), .Push(push), .WD(wd), .Pop(pop),
        .RD(rd0), .RD_Valid(rdv0), .Full(full0), .Empty(empty0),
        .Almost_Full(af0), .Almost_Empty(ae0), .Count(cnt0),
        .Overflow(ov0), .Underflow(un0)
    );

    ram_8k_fifo #(.data_width(9), .addr_width(11), .reg_rd(1)) dut1 (
        .Clk(Clk), .Rst(rst), .Flush(flush), .Push(push), .WD(wd[8:0]), .Pop(pop),
        .RD(rd1), .RD_Valid(rdv1), .Full(full1), .Empty(empty1),
        .Almost_Full(af1), .Almost_Empty(ae1), .Count(cnt1),
        .Overflow(ov1), .Underflow(un1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic        m_ov[2], m_un[2], m_rdv[2];
    logic [17:0] m_rd[2];
    logic        s1_v;
    logic [17:0] s1_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        int          depth;
        int          sz;
        logic        pop_ok, push_ok;
        logic [17:0] d;
        depth = (k == 0) ? 512 : 2048;
        sz    = (k == 0) ? q0.size() : q1.size();
        if (rst) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_ov[k] = 0; m_un[k] = 0; m_rd[k] = '0; m_rdv[k] = 0;
            if (k == 1) s1_v = 0;
        end else if (flush) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_ov[k] = 0; m_un[k] = 0; m_rdv[k] = 0;
            if (k == 1) s1_v = 0;
        end else begin
            pop_ok  = pop && (sz > 0);
            push_ok = push && ((sz < depth) || pop_ok);
            if (pop && !pop_ok)   m_un[k] = 1;
            if (push && !push_ok) m_ov[k] = 1;
            d = '0;
            if (pop_ok) d = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (push_ok) begin
                if (k == 0) q0.push_back(wd);
                else        q1.push_back({9'b0, wd[8:0]});
            end
            if (k == 0) begin
                m_rdv[0] = pop_ok;
                if (pop_ok) m_rd[0] = d;
            end else begin
                m_rdv[1] = s1_v;
                if (s1_v) m_rd[1] = s1_d;
                s1_v = pop_ok;
                s1_d = d;
            end
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q0.size();
        chk("cnt0", {22'b0, cnt0}, sz);
        chk("flags0", {26'b0, full0, empty0, af0, ae0, ov0, un0},
            {26'b0, sz == 512, sz == 0, sz >= 508, sz <= 4, m_ov[0], m_un[0]});
        chk("rdv0", {31'b0, rdv0}, {31'b0, m_rdv[0]});
        chk("rd0", {14'b0, rd0}, {14'b0, m_rd[0]});
        sz = q1.size();
        chk("cnt1", {20'b0, cnt1}, sz);
        chk("flags1", {26'b0, full1, empty1, af1, ae1, ov1, un1},
            {26'b0, sz == 2048, sz == 0, sz >= 2044, sz <= 4, m_ov[1], m_un[1]});
        chk("rdv1", {31'b0, rdv1}, {31'b0, m_rdv[1]});
        chk("rd1", {23'b0, rd1}, {14'b0, m_rd[1]});
    endtask

    task automatic cyc(input logic r, input logic f, input logic pu, input logic po,
                       input logic [17:0] d);
        rst = r; flush = f; push = pu; pop = po; wd = d;
        @(posedge Clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    initial begin
        int r;
        int max300;
        rst = 1; flush = 0; push = 0; pop = 0; wd = '0;
        s1_v = 0; s1_d = '0;

        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);

        // Fill with 0..511, then one push too many
        for (int i = 0; i < 512; i++) cyc(0, 0, 1, 0, 18'(i));
        cyc(0, 0, 1, 0, 18'h3FFFF);
        // Drain in order, then one pop too many
        for (int i = 0; i < 512; i++) cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);

        // Push+pop on empty accepts only the push
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 1, 1, 18'h00123);
        for (int i = 0; i < 511; i++) cyc(0, 0, 1, 0, 18'($urandom));
        // Push+pop on full keeps Count and Full
        cyc(0, 0, 1, 1, 18'h2AAAA);
        for (int i = 0; i < 513; i++) cyc(0, 0, 0, 1, '0);

        // Wrap-around bursts
        cyc(0, 1, 0, 0, '0);
        max300 = 0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 300; i++) begin
                cyc(0, 0, 1, 0, 18'($urandom));
                if (q0.size() > max300) max300 = q0.size();
            end
            for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1, '0);
        end
        chk("wrap_max", {22'b0, cnt0} + 32'(max300), 32'd300);

        // Random traffic with push-heavy and pop-heavy phases
        for (int i = 0; i < 4000; i++) begin
            int bias;
            bias = ((i / 600) % 2 == 0) ? 80 : 25;
            r = $urandom_range(0, 999);
            cyc(r < 2, (r >= 2 && r < 6),
                $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
                18'($urandom));
        end

        // Pipelined read timing on the reg_rd=1 instance
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 1, 0, 18'h001FF);
        cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 0, '0);
        chk("pipe_v", {31'b0, rdv1}, 32'd1);
        chk("pipe_d", {23'b0, rd1}, 32'h1FF);
        cyc(0, 0, 0, 0, '0);

        // Flush, then Rst, with a pop in flight at Count=5
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 18'(100 + i));
            cyc(0, 0, 1, 1, 18'h3FFFF);
            cyc(0, 0, 0, 1, '0);
            cyc(pass == 1, pass == 0, 1, 1, 18'h00055);
            chk("clr_cnt", {22'b0, cnt0}, 32'd0);
            chk("clr_v", {30'b0, rdv0, rdv1}, 32'd0);
            cyc(0, 0, 0, 0, '0);
            chk("clr_v2", {31'b0, rdv1}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
